// File: rtl/iter_divider.sv
// Iterative unsigned divider: radix-2 restoring, BITS_PER_CYCLE quotient bits per busy cycle.
// Latency: WIDTH/BITS_PER_CYCLE busy cycles after the accepted start edge, then a one-cycle done pulse.
// Backpressure: none; start is ignored while busy, one division in flight at a time.
module iter_divider #(
    parameter int WIDTH          = 64,
    parameter int BITS_PER_CYCLE = 8    // must divide WIDTH exactly
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done,
    output logic             busy,
    output logic             div_by_zero
);

    localparam int STEPS = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(STEPS + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q,  state_d;
    logic [CNT_W-1:0]   count_q,  count_d;
    // dvd_q shifts dividend bits out of the MSB and quotient bits in at the LSB
    logic [WIDTH-1:0]   dvd_q,    dvd_d;
    logic [WIDTH-1:0]   dvs_q,    dvs_d;
    // one extra bit so the shifted partial remainder never overflows the compare
    logic [WIDTH:0]     rem_q,    rem_d;
    logic [WIDTH-1:0]   quo_q,    quo_d;
    logic [WIDTH-1:0]   remo_q,   remo_d;
    logic               dbz_q,    dbz_d;

    logic [WIDTH:0]     r_step;
    logic [WIDTH-1:0]   q_step;

    // BITS_PER_CYCLE restoring steps chained combinationally, MSB first.
    // A zero divisor needs no special path: every compare succeeds, giving
    // all-ones quotient and the dividend as remainder.
    always_comb begin
        r_step = rem_q;
        q_step = dvd_q;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            r_step = {r_step[WIDTH-1:0], q_step[WIDTH-1]};
            q_step = {q_step[WIDTH-2:0], 1'b0};
            if (r_step >= {1'b0, dvs_q}) begin
                r_step    = r_step - {1'b0, dvs_q};
                q_step[0] = 1'b1;
            end
        end
    end

    // Next-state: accept in IDLE or DONE (back-to-back), iterate in BUSY,
    // publish results only on the BUSY->DONE edge.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        remo_d  = remo_q;
        dbz_d   = dbz_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    dvd_d   = dividend;
                    dvs_d   = divisor;
                    rem_d   = '0;
                    count_d = '0;
                    state_d = S_BUSY;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                dvd_d   = q_step;
                rem_d   = r_step;
                count_d = count_q + 1'b1;
                if (count_q == LAST) begin
                    quo_d   = q_step;
                    remo_d  = r_step[WIDTH-1:0];
                    dbz_d   = (dvs_q == '0);
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any division in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            remo_q  <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            remo_q  <= remo_d;
            dbz_q   <= dbz_d;
        end
    end

    assign quotient    = quo_q;
    assign remainder   = remo_q;
    assign div_by_zero = dbz_q;
    assign done        = (state_q == S_DONE);
    assign busy        = (state_q == S_BUSY);

endmodule

// File: tb/tb_iter_divider.sv
// Bench for iter_divider: vector table plus hand sequences for multi-cycle corners.
// Latency: expects done exactly L+1 cycles after an accepted start.
// Backpressure: checks that start while busy is ignored and held start re-issues on DONE.
module tb_iter_divider;

    localparam int L = 8;

    logic        clock;
    logic        reset;
    logic        start;
    logic [63:0] dividend;
    logic [63:0] divisor;
    logic [63:0] quotient;
    logic [63:0] remainder;
    logic        done;
    logic        busy;
    logic        div_by_zero;

    iter_divider #(.WIDTH(64), .BITS_PER_CYCLE(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .done        (done),
        .busy        (busy),
        .div_by_zero (div_by_zero)
    );

    typedef struct {
        logic [63:0] q;
        logic [63:0] r;
        logic        dz;
    } exp_t;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] q;
        logic [63:0] r;
        logic        dz;
    } vec_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [63:0] q, input logic [63:0] r, input logic dz);
        exp_t e;
        e.q  = q;
        e.r  = r;
        e.dz = dz;
        sb.push_back(e);
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #2;
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual=1 required=0 q=%h r=%h", quotient, remainder);
                end else begin
                    e = sb.pop_front();
                    chk("sb_quotient", quotient, e.q);
                    chk("sb_remainder", remainder, e.r);
                    chk("sb_div_by_zero", 64'(div_by_zero), 64'(e.dz));
                end
            end
        end
    end

    // One isolated division with exact latency checks; operands scrambled after accept.
    task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] eq, input logic [63:0] er, input logic edz);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        push(eq, er, edz);
        tick();
        start    = 1'b0;
        dividend = {$urandom, $urandom};
        divisor  = {$urandom, $urandom};
        for (int k = 0; k < L; k++) begin
            chk("op_busy", 64'(busy), 64'd1);
            chk("op_no_early_done", 64'(done), 64'd0);
            tick();
        end
        chk("op_done", 64'(done), 64'd1);
        chk("op_busy_at_done", 64'(busy), 64'd0);
        tick();
        chk("op_done_single", 64'(done), 64'd0);
    endtask

    vec_t vecs[9];

    initial begin
        logic [63:0] ra;
        logic [63:0] rb;

        vecs[0] = '{64'd100, 64'd7, 64'd14, 64'd2, 1'b0};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0};
        vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0};
        vecs[3] = '{64'd5, 64'd9, 64'd0, 64'd5, 1'b0};
        vecs[4] = '{64'd1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1234, 1'b1};
        vecs[5] = '{64'd9, 64'd4, 64'd2, 64'd1, 1'b0};
        vecs[6] = '{64'd0, 64'd5, 64'd0, 64'd0, 1'b0};
        vecs[7] = '{64'h8000_0000_0000_0000, 64'd2, 64'h4000_0000_0000_0000, 64'd0, 1'b0};
        vecs[8] = '{64'd1000, 64'd10, 64'd100, 64'd0, 1'b0};

        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_quotient", quotient, 64'd0);
        chk("rst_remainder", remainder, 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_div_by_zero", 64'(div_by_zero), 64'd0);

        foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz);

        for (int i = 0; i < 6; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom} >> $urandom_range(0, 63);
            if (rb == 64'd0) rb = 64'd3;
            run_op(ra, rb, ra / rb, ra % rb, 1'b0);
        end

        // start while busy is ignored; done keeps its original timing
        dividend = 64'd100;
        divisor  = 64'd7;
        start    = 1'b1;
        push(64'd14, 64'd2, 1'b0);
        tick();
        for (int k = 0; k < L; k++) begin
            if (k == 2) begin
                dividend = 64'd50;
                divisor  = 64'd3;
                start    = 1'b1;
            end else begin
                start = 1'b0;
            end
            chk("ign_busy", 64'(busy), 64'd1);
            tick();
        end
        chk("ign_done_on_time", 64'(done), 64'd1);
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("ign_no_second_done", 64'(done), 64'd0);
            chk("ign_idle", 64'(busy), 64'd0);
        end

        // start held high: re-issue on the DONE edge with new operands
        dividend = 64'd100;
        divisor  = 64'd7;
        start    = 1'b1;
        push(64'd14, 64'd2, 1'b0);
        tick();
        for (int k = 0; k < L; k++) begin
            chk("held_busy1", 64'(busy), 64'd1);
            tick();
        end
        chk("held_done1", 64'(done), 64'd1);
        dividend = 64'd50;
        divisor  = 64'd3;
        push(64'd16, 64'd2, 1'b0);
        tick();
        for (int k = 0; k < L; k++) begin
            chk("held_busy2", 64'(busy), 64'd1);
            chk("held_q_stable", quotient, 64'd14);
            chk("held_r_stable", remainder, 64'd2);
            tick();
        end
        chk("held_done2", 64'(done), 64'd1);
        start = 1'b0;
        tick();
        chk("held_done2_single", 64'(done), 64'd0);
        chk("held_idle", 64'(busy), 64'd0);

        // reset mid-division: abandoned, outputs back to reset values
        dividend = 64'd100;
        divisor  = 64'd7;
        start    = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_quotient", quotient, 64'd0);
        chk("abort_remainder", remainder, 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_div_by_zero", 64'(div_by_zero), 64'd0);
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("abort_no_done", 64'(done), 64'd0);
        end
        run_op(64'd9, 64'd4, 64'd2, 64'd1, 1'b0);

        // reset and start on the same edge: reset wins
        dividend = 64'd9;
        divisor  = 64'd4;
        start    = 1'b1;
        reset    = 1'b1;
        tick();
        start = 1'b0;
        reset = 1'b0;
        chk("rst_start_busy", 64'(busy), 64'd0);
        chk("rst_start_q", quotient, 64'd0);
        repeat (10) tick();
        chk("rst_start_no_done", 64'(done), 64'd0);

        repeat (3) tick();
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/iter_divider.md
# iter_divider

Iterative unsigned 64-bit divider producing quotient and remainder. It is the inverse-operation companion to the 8-stage pipelined multiplier and shares its `start`/`done` convention. It retires `BITS_PER_CYCLE` quotient bits per cycle with radix-2 restoring division, so the default build has the same 8-cycle latency as the multiplier. It is not pipelined: one division is in flight at a time.

## Interface
- `WIDTH`, default 64: operand and result width.
- `BITS_PER_CYCLE`, default 8: quotient bits resolved per busy cycle. Must divide `WIDTH` exactly.
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high. Returns the block to IDLE and aborts any division in progress.
- `start` in 1: request. Sampled only when not busy.
- `dividend` in WIDTH: unsigned dividend. Captured on the accepted `start` edge.
- `divisor` in WIDTH: unsigned divisor. Captured on the accepted `start` edge.
- `quotient` out WIDTH: result quotient. Held until the next completion.
- `remainder` out WIDTH: result remainder. Held until the next completion.
- `done` out 1: one-cycle pulse. Results are valid in this cycle and afterwards.
- `busy` out 1: high while iterating. A `start` seen while busy is ignored.
- `div_by_zero` out 1: qualifies the current results. High when the captured divisor was 0.

## Operation
- States: IDLE, BUSY, DONE.
  - IDLE, `start`=1: capture operands. Clear the partial remainder. Set count := 0. Go to BUSY.
  - BUSY: perform `BITS_PER_CYCLE` restoring steps per cycle and increment count. When count reaches `WIDTH/BITS_PER_CYCLE`, write the results and go to DONE.
  - DONE: `done`=1 for this cycle only.
    - With `start`=1, behave exactly as IDLE with `start` (back-to-back issue is allowed).
    - Otherwise go to IDLE.
- Restoring step, MSB first:
  - r := {r[WIDTH-1:0], next dividend bit}. r is WIDTH+1 bits wide so the compare cannot overflow.
  - If r ≥ divisor: r := r − divisor and the quotient bit is 1. Otherwise the quotient bit is 0.
- All arithmetic is unsigned. There is no signed mode.
- Divide by zero follows naturally from the algorithm, with no special-case path:
  - `quotient` = all ones, `remainder` = `dividend`.
  - `div_by_zero`=1, with the same latency as a normal division.
- `quotient`, `remainder` and `div_by_zero` change only on the completion edge, i.e. the transition BUSY→DONE. They stay stable through IDLE and through a subsequent BUSY.
- Operand inputs are ignored except on an accepted `start` edge.
- `busy` = (state == BUSY).

## Timing
- Reset values:
  - State IDLE.
  - `quotient`, `remainder` = 0.
  - `done`, `busy`, `div_by_zero` = 0.
  - count = 0.
- Latency: with `start` accepted at edge E, `busy`=1 after edge E through edge E+L−1, where L = `WIDTH/BITS_PER_CYCLE` (8 by default).
- `done`=1 and results are valid in the cycle following edge E+L.
- Throughput: one result every L+1 cycles.
- `start` while BUSY: no effect, no queueing, and the in-flight operation is unaffected.
- `start` held high continuously: a new operation is accepted on each DONE edge.
- Reset while BUSY: the operation is abandoned, no `done` pulse is produced, and outputs return to their reset values.
- Reset and `start` on the same edge: reset wins.

## Test plan
- Reset, then `dividend`=100, `divisor`=7, `start` pulsed one cycle → `busy` for 8 cycles, then `done` one cycle with `quotient`=14, `remainder`=2, `div_by_zero`=0.
- `dividend`=0xFFFF_FFFF_FFFF_FFFF, `divisor`=1 → `quotient`=0xFFFF_FFFF_FFFF_FFFF, `remainder`=0. Then `divisor`=0xFFFF_FFFF_FFFF_FFFF → `quotient`=1, `remainder`=0. Also `dividend`=5, `divisor`=9 → `quotient`=0, `remainder`=5.
- `dividend`=1234, `divisor`=0 → after 8 busy cycles `quotient`=all ones, `remainder`=1234, `div_by_zero`=1.
- Start 100/7, then change the operands to 50/3 and pulse `start` at busy cycle 3 → `done` still arrives at the original time with 14 r 2, and no second `done` follows.
- `start` held high with operands 100/7, then 50/3 presented during the DONE cycle → first `done` shows 14 r 2. Second `done` arrives exactly 9 cycles later with 16 r 2, and results stay 14/2 in between.
- Start 100/7, assert `reset` at busy cycle 4 → no `done`, and all outputs read 0. A fresh 9/4 afterwards → 2 r 1 with normal latency.
